// File: rtl/hazard_scoreboard_if.sv
// Hazard unit interface: D-stage operand/writer info in, stall and forwarding selects out.
// The pipeline side uses the master modport, the hazard unit the slave modport.
interface hazard_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int TNEW_W = 2
);
    localparam int SEL_W = $clog2(STAGES + 1);

    logic              flush;
    logic [4:0]        d_rs;
    logic [4:0]        d_rt;
    logic [TNEW_W-1:0] rs_tuse;
    logic [TNEW_W-1:0] rt_tuse;
    logic              d_we;
    logic [4:0]        d_dst;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_is_mdu;
    logic              d_mdu_start;
    logic              d_mdu_div;

    logic              stall;
    logic              mdu_busy;
    logic [SEL_W-1:0]  fwd_rs_d;
    logic [SEL_W-1:0]  fwd_rt_d;
    logic [SEL_W-1:0]  fwd_rs_e;
    logic [SEL_W-1:0]  fwd_rt_e;
    logic [SEL_W-1:0]  fwd_rt_m;

    modport master (
        output flush, d_rs, d_rt, rs_tuse, rt_tuse, d_we, d_dst, d_tnew,
               d_is_mdu, d_mdu_start, d_mdu_div,
        input  stall, mdu_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );

    modport slave (
        input  flush, d_rs, d_rt, rs_tuse, rt_tuse, d_we, d_dst, d_tnew,
               d_is_mdu, d_mdu_start, d_mdu_div,
        output stall, mdu_busy, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: shift queue of in-flight writers drives stall and D/E/M forward selects.
// Optional HI/LO busy counter is built only when HAZARD_MDU_EN is defined.
module hazard_scoreboard #(
    parameter int STAGES   = 3,
    parameter int TNEW_W   = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic              clk,
    input logic              reset,
    hazard_scoreboard_if.slave hz
);
    localparam int SEL_W = $clog2(STAGES + 1);

    // Entry 1 is E, entry STAGES is W.
    logic              valid_q [1:STAGES];
    logic              valid_d [1:STAGES];
    logic [4:0]        dst_q   [1:STAGES];
    logic [4:0]        dst_d   [1:STAGES];
    logic [TNEW_W-1:0] tnew_q  [1:STAGES];
    logic [TNEW_W-1:0] tnew_d  [1:STAGES];
    logic [4:0]        rs_q    [1:STAGES];
    logic [4:0]        rs_d    [1:STAGES];
    logic [4:0]        rt_q    [1:STAGES];
    logic [4:0]        rt_d    [1:STAGES];

    logic stall_w;
    logic issue_en;
    logic mdu_busy_w;
    logic mdu_stall;

    assign issue_en = !stall_w && !hz.flush;

    always_comb begin
        valid_d[1] = issue_en && hz.d_we && (hz.d_dst != 5'd0);
        dst_d[1]   = issue_en ? hz.d_dst  : 5'd0;
        tnew_d[1]  = issue_en ? hz.d_tnew : '0;
        rs_d[1]    = issue_en ? hz.d_rs   : 5'd0;
        rt_d[1]    = issue_en ? hz.d_rt   : 5'd0;
        for (int k = 2; k <= STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            dst_d[k]   = dst_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] != '0) ? tnew_q[k-1] - TNEW_W'(1) : '0;
            rs_d[k]    = rs_q[k-1];
            rt_d[k]    = rt_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                valid_q[k] <= 1'b0;
                dst_q[k]   <= 5'd0;
                tnew_q[k]  <= '0;
                rs_q[k]    <= 5'd0;
                rt_q[k]    <= 5'd0;
            end
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                dst_q[k]   <= dst_d[k];
                tnew_q[k]  <= tnew_d[k];
                rs_q[k]    <= rs_d[k];
                rt_q[k]    <= rt_d[k];
            end
        end
    end

    logic [STAGES:1] ready;
    logic [STAGES:1] hit_rs_d;
    logic [STAGES:1] hit_rt_d;
    logic [STAGES:1] late_rs;
    logic [STAGES:1] late_rt;
    logic [STAGES:1] hit_rs_e;
    logic [STAGES:1] hit_rt_e;
    logic [STAGES:1] hit_rt_m;

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_ent
            logic live;
            assign live         = valid_q[gi] && (dst_q[gi] != 5'd0);
            assign ready[gi]    = (tnew_q[gi] == '0);
            assign hit_rs_d[gi] = live && (dst_q[gi] == hz.d_rs);
            assign hit_rt_d[gi] = live && (dst_q[gi] == hz.d_rt);
            assign late_rs[gi]  = hit_rs_d[gi] && (hz.rs_tuse < tnew_q[gi]);
            assign late_rt[gi]  = hit_rt_d[gi] && (hz.rt_tuse < tnew_q[gi]);
            // E consumer is entry 1 itself, M consumer is entry 2: only older entries can feed them.
            assign hit_rs_e[gi] = (gi >= 2) && live && (dst_q[gi] == rs_q[1]);
            assign hit_rt_e[gi] = (gi >= 2) && live && (dst_q[gi] == rt_q[1]);
            assign hit_rt_m[gi] = (gi >= 3) && live && (dst_q[gi] == rt_q[2]);
        end
    endgenerate

    // Youngest match decides; if it is still pending, an older ready entry must not be used.
    function automatic logic [SEL_W-1:0] pick(input logic [STAGES:1] hit,
                                              input logic [STAGES:1] rdy);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (hit[k]) begin
                sel = rdy[k] ? SEL_W'(k) : '0;
            end
        end
        return sel;
    endfunction

`ifdef HAZARD_MDU_EN
    localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (issue_en && hz.d_mdu_start) begin
            cnt_d = hz.d_mdu_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdu_busy_w = (cnt_q != '0);
    assign mdu_stall  = hz.d_is_mdu && mdu_busy_w;
`else
    logic unused_mdu;
    assign unused_mdu = ^{hz.d_is_mdu, hz.d_mdu_start, hz.d_mdu_div,
                          (MULT_LAT > 0), (DIV_LAT > 0)};
    assign mdu_busy_w = 1'b0;
    assign mdu_stall  = 1'b0;
`endif

    assign stall_w     = (|late_rs) || (|late_rt) || mdu_stall;
    assign hz.stall    = stall_w;
    assign hz.mdu_busy = mdu_busy_w;
    assign hz.fwd_rs_d = pick(hit_rs_d, ready);
    assign hz.fwd_rt_d = pick(hit_rt_d, ready);
    assign hz.fwd_rs_e = pick(hit_rs_e, ready);
    assign hz.fwd_rt_e = pick(hit_rt_e, ready);
    assign hz.fwd_rt_m = pick(hit_rt_m, ready);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3): a per-cycle history model checks every
// output each cycle, and literal expectations pin the key scenarios.
module tb_hazard_scoreboard;
    localparam int S  = 3;
    localparam int TW = 2;
    localparam int ML = 5;
    localparam int DL = 10;
`ifdef HAZARD_MDU_EN
    localparam bit MDU_ON = 1'b1;
`else
    localparam bit MDU_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STAGES(S), .TNEW_W(TW)) hz();
    hazard_scoreboard #(.STAGES(S), .TNEW_W(TW), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // History model: what D handed to E at the end of each cycle, indexed by cycle number.
    int         cyc      = 0;
    int         rst_mark = -1;
    int         mstart   = -1000;
    int         mlat     = 0;
    bit         rec_v    [0:1023];
    logic [4:0] rec_dst  [0:1023];
    logic [4:0] rec_rs   [0:1023];
    logic [4:0] rec_rt   [0:1023];
    int         rec_tnew [0:1023];

    function automatic bit ent_ok(int k);
        int p = cyc - k;
        return (p >= 0) && (p > rst_mark);
    endfunction

    function automatic bit ent_hit(int k, logic [4:0] r);
        int p = cyc - k;
        if (!ent_ok(k)) return 1'b0;
        return rec_v[p] && (rec_dst[p] != 5'd0) && (rec_dst[p] == r);
    endfunction

    function automatic int ent_tnew(int k);
        int t;
        if (!ent_ok(k)) return 0;
        t = rec_tnew[cyc - k] - (k - 1);
        return (t < 0) ? 0 : t;
    endfunction

    function automatic logic [4:0] ent_rs(int k);
        return ent_ok(k) ? rec_rs[cyc - k] : 5'd0;
    endfunction

    function automatic logic [4:0] ent_rt(int k);
        return ent_ok(k) ? rec_rt[cyc - k] : 5'd0;
    endfunction

    function automatic int youngest(logic [4:0] r, int from);
        for (int k = from; k <= S; k++) begin
            if (ent_hit(k, r)) return (ent_tnew(k) == 0) ? k : 0;
        end
        return 0;
    endfunction

    function automatic bit exp_busy();
        return MDU_ON && (cyc > mstart) && (cyc <= mstart + mlat);
    endfunction

    function automatic bit exp_stall();
        bit s = 1'b0;
        for (int k = 1; k <= S; k++) begin
            if (ent_hit(k, hz.d_rs) && (int'(hz.rs_tuse) < ent_tnew(k))) s = 1'b1;
            if (ent_hit(k, hz.d_rt) && (int'(hz.rt_tuse) < ent_tnew(k))) s = 1'b1;
        end
        if (hz.d_is_mdu && exp_busy()) s = 1'b1;
        return s;
    endfunction

    task automatic check(string name, logic [7:0] act, int exp);
        n_cmp++;
        if (act !== 8'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        check("model_stall",    8'(hz.stall),    int'(exp_stall()));
        check("model_mdu_busy", 8'(hz.mdu_busy), int'(exp_busy()));
        check("model_fwd_rs_d", 8'(hz.fwd_rs_d), youngest(hz.d_rs, 1));
        check("model_fwd_rt_d", 8'(hz.fwd_rt_d), youngest(hz.d_rt, 1));
        check("model_fwd_rs_e", 8'(hz.fwd_rs_e), youngest(ent_rs(1), 2));
        check("model_fwd_rt_e", 8'(hz.fwd_rt_e), youngest(ent_rt(1), 2));
        check("model_fwd_rt_m", 8'(hz.fwd_rt_m), youngest(ent_rt(2), 3));
    endtask

    task automatic model_record();
        bit iss;
        iss = !reset && !hz.flush && !exp_stall();
        if (reset) begin
            rst_mark = cyc;
            mstart   = -1000;
        end
        rec_v[cyc]    = iss && hz.d_we && (hz.d_dst != 5'd0);
        rec_dst[cyc]  = iss ? hz.d_dst : 5'd0;
        rec_rs[cyc]   = iss ? hz.d_rs : 5'd0;
        rec_rt[cyc]   = iss ? hz.d_rt : 5'd0;
        rec_tnew[cyc] = iss ? int'(hz.d_tnew) : 0;
        if (iss && hz.d_mdu_start) begin
            mstart = cyc;
            mlat   = hz.d_mdu_div ? DL : ML;
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
        $display("cyc=%0d rst=%0b flush=%0b rs=%0d rt=%0d we=%0b dst=%0d stall=%0b busy=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d fwd_m=%0d",
                 cyc, reset, hz.flush, hz.d_rs, hz.d_rt, hz.d_we, hz.d_dst, hz.stall, hz.mdu_busy,
                 hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e, hz.fwd_rt_m);
    endtask

    task automatic advance();
        @(posedge clk);
        model_record();
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drive(logic we, logic [4:0] dst, int tnew, logic [4:0] rs, logic [4:0] rt,
                         int rtu, int ttu, logic mdu, logic st, logic dv);
        hz.flush       = 1'b0;
        hz.d_we        = we;
        hz.d_dst       = dst;
        hz.d_tnew      = TW'(tnew);
        hz.d_rs        = rs;
        hz.d_rt        = rt;
        hz.rs_tuse     = TW'(rtu);
        hz.rt_tuse     = TW'(ttu);
        hz.d_is_mdu    = mdu;
        hz.d_mdu_start = st;
        hz.d_mdu_div   = dv;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 0, 5'd0, 5'd0, 3, 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(int n);
        nop();
        repeat (n) step();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        nop();
        advance();
        // Reset state with live-looking D inputs, including an MDU start that reset must swallow.
        drive(1'b1, 5'd1, 2, 5'd1, 5'd1, 0, 0, 1'b1, 1'b1, 1'b0);
        settle();
        check("rst_stall", 8'(hz.stall), 0);
        check("rst_busy", 8'(hz.mdu_busy), 0);
        check("rst_fwd_rs_d", 8'(hz.fwd_rs_d), 0);
        advance();
        reset = 1'b0;
        nop();
        settle();
        check("rst_no_mdu_load", 8'(hz.mdu_busy), 0);
        advance();

        // lw $1 then addu $2,$1,$1
        drive(1'b1, 5'd1, 2, 5'd29, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        settle();
        check("lw_nostall", 8'(hz.stall), 0);
        advance();
        drive(1'b1, 5'd2, 1, 5'd1, 5'd1, 1, 1, 1'b0, 1'b0, 1'b0);
        settle();
        check("lw_use_stall", 8'(hz.stall), 1);
        advance();
        settle();
        check("lw_use_release", 8'(hz.stall), 0);
        advance();
        nop();
        settle();
        check("lw_fwd_rs_e", 8'(hz.fwd_rs_e), 3);
        check("lw_fwd_rt_e", 8'(hz.fwd_rt_e), 3);
        advance();
        drain(3);

        // addu $3 then beq $3,$0
        drive(1'b1, 5'd3, 1, 5'd7, 5'd8, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 0, 5'd3, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        check("beq_stall", 8'(hz.stall), 1);
        advance();
        settle();
        check("beq_release", 8'(hz.stall), 0);
        check("beq_fwd_rs_d", 8'(hz.fwd_rs_d), 2);
        check("beq_fwd_rt_d", 8'(hz.fwd_rt_d), 0);
        advance();
        drain(3);

        // ori $4, ori $4, addu $5,$4: younger producer must win
        drive(1'b1, 5'd4, 1, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        settle();
        check("ori2_nostall", 8'(hz.stall), 0);
        advance();
        drive(1'b1, 5'd5, 1, 5'd4, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        settle();
        check("ori_addu_nostall", 8'(hz.stall), 0);
        check("ori_no_old_fwd_d", 8'(hz.fwd_rs_d), 0);
        advance();
        nop();
        settle();
        check("ori_young_fwd_e", 8'(hz.fwd_rs_e), 2);
        advance();
        drain(3);

        // writer to $0 then reader of $0
        drive(1'b1, 5'd0, 2, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        check("r0_stall", 8'(hz.stall), 0);
        check("r0_fwd_rs_d", 8'(hz.fwd_rs_d), 0);
        check("r0_fwd_rt_d", 8'(hz.fwd_rt_d), 0);
        advance();
        nop();
        settle();
        check("r0_fwd_rs_e", 8'(hz.fwd_rs_e), 0);
        advance();
        drain(2);

        // flushed writer never enters the queue
        drive(1'b1, 5'd7, 2, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        hz.flush = 1'b1;
        step();
        drive(1'b0, 5'd0, 0, 5'd7, 5'd7, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        check("flushed_no_stall", 8'(hz.stall), 0);
        check("flushed_no_fwd", 8'(hz.fwd_rs_d), 0);
        advance();
        drain(3);

        // flush during a stall still leaves D frozen and injects a bubble
        drive(1'b1, 5'd1, 2, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd2, 1, 5'd1, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        hz.flush = 1'b1;
        settle();
        check("flush_keeps_stall", 8'(hz.stall), 1);
        advance();
        hz.flush = 1'b0;
        settle();
        check("flush_release", 8'(hz.stall), 0);
        advance();
        nop();
        settle();
        check("flush_fwd_rs_e", 8'(hz.fwd_rs_e), 3);
        advance();
        drain(3);

        // a writer leaves the queue STAGES cycles after issue
        drive(1'b1, 5'd9, 1, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        drain(2);
        drive(1'b0, 5'd0, 0, 5'd9, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        check("last_entry_fwd", 8'(hz.fwd_rs_d), 3);
        advance();
        settle();
        check("discarded_fwd", 8'(hz.fwd_rs_d), 0);
        advance();
        drain(3);

        // mult then mflo
        drive(1'b0, 5'd0, 0, 5'd8, 5'd9, 1, 1, 1'b1, 1'b1, 1'b0);
        settle();
        check("mult_issue", 8'(hz.stall), 0);
        advance();
        drive(1'b1, 5'd6, 1, 5'd0, 5'd0, 3, 3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < ML; i++) begin
            settle();
            check("mult_stall", 8'(hz.stall), MDU_ON ? 1 : 0);
            check("mult_busy", 8'(hz.mdu_busy), MDU_ON ? 1 : 0);
            advance();
        end
        settle();
        check("mult_done_stall", 8'(hz.stall), 0);
        check("mult_done_busy", 8'(hz.mdu_busy), 0);
        advance();
        drain(3);

        // div then mflo: count stall cycles within a bounded window
        drive(1'b0, 5'd0, 0, 5'd8, 5'd9, 1, 1, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd6, 1, 5'd0, 5'd0, 3, 3, 1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (hz.stall !== 1'b1) break;
            n++;
            advance();
        end
        check("div_stall_cycles", 8'(n), MDU_ON ? DL : 0);
        advance();
        drain(3);

        // reset in the middle of a load-use stall
        drive(1'b1, 5'd1, 2, 5'd0, 5'd0, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 1, 5'd1, 5'd1, 1, 1, 1'b0, 1'b0, 1'b0);
        settle();
        check("pre_rst_stall", 8'(hz.stall), 1);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        check("post_rst_stall", 8'(hz.stall), 0);
        check("post_rst_fwd_rs_d", 8'(hz.fwd_rs_d), 0);
        check("post_rst_fwd_rt_d", 8'(hz.fwd_rt_d), 0);
        check("post_rst_fwd_rs_e", 8'(hz.fwd_rs_e), 0);
        check("post_rst_fwd_rt_e", 8'(hz.fwd_rt_e), 0);
        check("post_rst_fwd_rt_m", 8'(hz.fwd_rt_m), 0);
        advance();
        drain(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the pipelined MIPS core, one generation past the per-stage combinational Tuse/Tnew comparator. It owns a shift queue of in-flight register writers instead of reading destination/Tnew fields from the pipeline registers. From that queue it drives stall and forwarding selects for the D, E and M consumers at any post-decode depth. It also contains a multi-cycle MDU busy counter, so HI/LO hazards are resolved locally.

## Interface
Parameters:
- STAGES, 3: number of post-decode stages; entry 1 = E, entry STAGES = W; must be ≥3.
- TNEW_W, 2: width of Tnew/Tuse fields.
- MULT_LAT, 5: MDU busy cycles for mult/multu.
- DIV_LAT, 10: MDU busy cycles for div/divu.
- SEL_W = $clog2(STAGES+1): localparam, forward-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  kill the D instruction: it does not enter entry 1.
- d_rs, d_rt  in  5 each  D source registers.
- rs_tuse, rt_tuse  in  TNEW_W each  D Tuse values.
- d_we  in  1  D instruction writes the GPR file.
- d_dst  in  5  D destination register.
- d_tnew  in  TNEW_W  Tnew of the D instruction at its arrival in E.
- d_is_mdu  in  1  D instruction reads or writes HI/LO or starts the MDU.
- d_mdu_start  in  1  D is mult/multu/div/divu.
- d_mdu_div  in  1  the start is a divide.
- stall  out  1  freeze F/D, bubble into E.
- mdu_busy  out  1  MDU counter nonzero.
- fwd_rs_d, fwd_rt_d  out  SEL_W each  select for the D consumer: 0 = register file; k = entry k.
- fwd_rs_e, fwd_rt_e  out  SEL_W each  select for the E consumer, encoded as above.
- fwd_rt_m  out  SEL_W  select for the M consumer, encoded as above.

## Operation
- Queue entry k (1..STAGES) holds {valid, dst, tnew, rs, rt}.
- Every cycle, entry k moves to k+1; entry STAGES is discarded.
- Each moved tnew is decremented, saturating at 0.
- Entry 1 loads {d_we && d_dst≠0, d_dst, d_tnew, d_rs, d_rt} only when the enable term holds: !stall && !flush.
- Otherwise entry 1 loads the bubble value: valid=0, dst=0, rs=0, rt=0.
- A match at entry k requires valid, dst≠0 and dst equal to the consumer register.
- Stall: assert when any entry k matches d_rs with rs_tuse < tnew[k], or matches d_rt with rt_tuse < tnew[k].
- MDU stall: with MDU enabled, d_is_mdu && mdu_busy also asserts stall.
- D selects: the smallest k in 1..STAGES whose entry matches with tnew[k]==0; otherwise 0.
- E selects: compare entry 1's rs/rt against entries 2..STAGES and pick the smallest matching k with tnew 0; otherwise 0.
- M select: compare entry 2's rt against entries 3..STAGES and pick the smallest matching k with tnew 0; otherwise 0.
- Youngest matching producer always wins. An older tnew==0 entry must not be selected over a younger match still pending; the stall covers that case.
- MDU counter: when d_mdu_start is issued (!stall && !flush), load DIV_LAT if d_mdu_div, else MULT_LAT.
- Otherwise the counter decrements when nonzero.
- mdu_busy = (counter ≠ 0).
- All outputs are combinational from the queue, the counter and the D inputs.

## Timing
- Reset: all entries invalid with fields 0, counter 0.
- After reset, stall=0, mdu_busy=0 and all fwd_*=0 for any D inputs.
- reset overrides flush and issue on the same edge.
- Reset mid-stall: stall drops the cycle after the reset edge.
- An issued writer is visible in entry 1 one cycle after its D cycle.
- It is discarded STAGES cycles after issue. From then on, the register file must supply its value; the RF writes in W and reads the same cycle.
- Simultaneous flush and stall produce a bubble. flush never unfreezes D; the front end handles PC.
- Simultaneous d_mdu_start and a nonzero counter: no load, because stall is asserted.

## Configuration
- HAZARD_MDU_EN defined: MDU counter and MDU stall are present as described.
- HAZARD_MDU_EN undefined: counter removed, mdu_busy tied 0, the d_mdu_* and d_is_mdu inputs are ignored, and stall comes from GPR hazards only.

## Test plan
All scenarios use STAGES=3.
- lw $1 (tnew 2) then addu $2,$1,$1 (rs_tuse=rt_tuse=1) -> stall=1 for exactly 1 cycle; next, with addu in E, fwd_rs_e=fwd_rt_e=3.
- addu $3 (tnew 1) then beq $3,$0 (rs_tuse 0) -> stall 1 cycle, then fwd_rs_d=2, fwd_rt_d=0.
- ori $4, ori $4, then addu $5,$4 (tuse 1), all tnew 1 -> no stall; addu's rs is forwarded from the younger ori, never the older one.
- Writer with d_dst=0 and d_we=1, then a reader of $0 -> stall=0, all fwd=0.
- mult then mflo (d_is_mdu) -> stall for 5 cycles, mdu_busy falls on the 6th.
- div then mflo -> 10 stall cycles. Without HAZARD_MDU_EN -> stall=0.
- lw $1 stalling addu $1, then reset asserted one cycle -> the cycle after the reset edge, stall=0 and all fwd=0.
